// File: rtl/jtag_dmi_target.sv
// DMI target for a JTAG DTM: request handshake, debug-module registers
// and an emulated hart with a latency-modelled abstract command engine.
module jtag_dmi_target #(
   parameter int unsigned ACCESS_LATENCY = 1,
   parameter int unsigned CMD_LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  dmi_addr,
   input  logic [31:0] dmi_wdata,
   input  logic [1:0]  dmi_op,
   input  logic        dmi_req_valid,
   output logic        dmi_req_ready,
   output logic [31:0] dmi_rdata,
   output logic [1:0]  dmi_resp,
   output logic        dmactive,
   output logic        ndmreset,
   output logic        halted
);

   localparam logic [6:0] A_DATA0 = 7'h04;
   localparam logic [6:0] A_DATA1 = 7'h05;
   localparam logic [6:0] A_DMCTL = 7'h10;
   localparam logic [6:0] A_DMSTS = 7'h11;
   localparam logic [6:0] A_ABSCS = 7'h16;
   localparam logic [6:0] A_CMD   = 7'h17;

   localparam logic [3:0] LAT = 4'(ACCESS_LATENCY);
   localparam logic [7:0] CLAT = 8'(CMD_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  lat_q, lat_d;
   logic [6:0]  addr_q, addr_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] wdata_q, wdata_d;
   logic        enter_resp;

   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  resp_q, resp_d;
   logic [31:0] data0_q, data0_d;
   logic [31:0] data1_q, data1_d;
   logic        dmactive_q, dmactive_d;
   logic        ndmreset_q, ndmreset_d;
   logic        halted_q, halted_d;
   logic        resumeack_q, resumeack_d;
   logic        busy_q, busy_d;
   logic [2:0]  cmderr_q, cmderr_d;
   logic [7:0]  ccnt_q, ccnt_d;
   logic [17:0] cmd_q, cmd_d;

   logic [6:0]  cur_addr;
   logic [1:0]  cur_op;
   logic [31:0] cur_wdata;
   logic        is_rd, is_wr, blocked;
   logic [31:0] rd_val;
   logic [31:0] dmsts, abscs;

   // With zero access latency the request is served straight from the inputs.
   assign cur_addr  = (state_q == S_IDLE) ? dmi_addr  : addr_q;
   assign cur_op    = (state_q == S_IDLE) ? dmi_op    : op_q;
   assign cur_wdata = (state_q == S_IDLE) ? dmi_wdata : wdata_q;

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      addr_d     = addr_q;
      op_d       = op_q;
      wdata_d    = wdata_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dmi_req_valid) begin
               addr_d  = dmi_addr;
               op_d    = dmi_op;
               wdata_d = dmi_wdata;
               if (ACCESS_LATENCY == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  lat_d   = LAT;
               end
            end
         end
         S_WAIT: begin
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign dmsts = {14'b0, resumeack_q, resumeack_q, 4'b0,
                   ~halted_q, ~halted_q, halted_q, halted_q,
                   1'b1, 3'b0, 4'd2};
   assign abscs = {19'b0, busy_q, 1'b0, cmderr_q, 4'b0, 4'd2};

   always_comb begin
      rd_val = 32'h0;
      case (cur_addr)
         A_DATA0: rd_val = data0_q;
         A_DATA1: rd_val = data1_q;
         A_DMCTL: rd_val = {30'b0, ndmreset_q, dmactive_q};
         A_DMSTS: rd_val = dmsts;
         A_ABSCS: rd_val = abscs;
         default: rd_val = 32'h0;
      endcase
   end

   assign is_rd   = enter_resp && (cur_op == 2'd1);
   assign is_wr   = enter_resp && (cur_op == 2'd2);
   assign blocked = busy_q && ((cur_addr == A_DATA0) ||
                    (cur_addr == A_DATA1) || (cur_addr == A_CMD));

   always_comb begin
      rdata_d     = rdata_q;
      resp_d      = resp_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      dmactive_d  = dmactive_q;
      ndmreset_d  = ndmreset_q;
      halted_d    = halted_q;
      resumeack_d = resumeack_q;
      busy_d      = busy_q;
      cmderr_d    = cmderr_q;
      ccnt_d      = ccnt_q;
      cmd_d       = cmd_q;

      if (busy_q) begin
         ccnt_d = ccnt_q - 8'd1;
         if (ccnt_q == 8'd1) begin
            busy_d = 1'b0;
            if (cmd_q[17] && !cmd_q[16])
               data0_d = {16'h0, cmd_q[15:0]};
         end
      end

      if (enter_resp)
         resp_d = (cur_op == 2'd3) ? 2'd2 : 2'd0;

      if ((is_rd || is_wr) && blocked) begin
         if (cmderr_q == 3'd0)
            cmderr_d = 3'd1;
         if (is_rd)
            rdata_d = 32'h0;
      end else if (is_rd) begin
         rdata_d = rd_val;
      end else if (is_wr) begin
         if (cur_addr == A_DMCTL) begin
            dmactive_d = cur_wdata[0];
            if (dmactive_q) begin
               ndmreset_d = cur_wdata[1];
               if (cur_wdata[31]) begin
                  halted_d    = 1'b1;
                  resumeack_d = 1'b0;
               end else if (cur_wdata[30]) begin
                  halted_d    = 1'b0;
                  resumeack_d = 1'b1;
               end
            end
         end else if (dmactive_q) begin
            case (cur_addr)
               A_DATA0: data0_d = cur_wdata;
               A_DATA1: data1_d = cur_wdata;
               A_ABSCS: cmderr_d = cmderr_q & ~cur_wdata[10:8];
               A_CMD: begin
                  if (cmderr_q == 3'd0) begin
                     if (cur_wdata[31:24] != 8'd0) begin
                        cmderr_d = 3'd2;
                     end else if (!halted_q) begin
                        cmderr_d = 3'd4;
                     end else begin
                        busy_d = 1'b1;
                        ccnt_d = CLAT;
                        cmd_d  = cur_wdata[17:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      // An inactive debug module pins its state at reset and kills any command.
      if (!dmactive_q) begin
         data0_d     = 32'h0;
         data1_d     = 32'h0;
         ndmreset_d  = 1'b0;
         halted_d    = 1'b0;
         resumeack_d = 1'b0;
         busy_d      = 1'b0;
         cmderr_d    = 3'd0;
         ccnt_d      = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         lat_q       <= 4'd0;
         addr_q      <= 7'd0;
         op_q        <= 2'd0;
         wdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         resp_q      <= 2'd0;
         data0_q     <= 32'h0;
         data1_q     <= 32'h0;
         dmactive_q  <= 1'b0;
         ndmreset_q  <= 1'b0;
         halted_q    <= 1'b0;
         resumeack_q <= 1'b0;
         busy_q      <= 1'b0;
         cmderr_q    <= 3'd0;
         ccnt_q      <= 8'd0;
         cmd_q       <= 18'd0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         addr_q      <= addr_d;
         op_q        <= op_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         dmactive_q  <= dmactive_d;
         ndmreset_q  <= ndmreset_d;
         halted_q    <= halted_d;
         resumeack_q <= resumeack_d;
         busy_q      <= busy_d;
         cmderr_q    <= cmderr_d;
         ccnt_q      <= ccnt_d;
         cmd_q       <= cmd_d;
      end
   end

   assign dmi_req_ready = (state_q == S_RESP);
   assign dmi_rdata     = rdata_q;
   assign dmi_resp      = resp_q;
   assign dmactive      = dmactive_q;
   assign ndmreset      = ndmreset_q;
   assign halted        = halted_q;

endmodule

// File: tb/tb_jtag_dmi_target.sv
// Bench for jtag_dmi_target: DTM-style requests with a response scoreboard
// and reset, data, abstract-command, halt/resume and mid-transfer-reset cases.
module tb_jtag_dmi_target;

   logic        clk;
   logic        rst_n;
   logic [6:0]  dmi_addr;
   logic [31:0] dmi_wdata;
   logic [1:0]  dmi_op;
   logic        dmi_req_valid;
   logic        dmi_req_ready;
   logic [31:0] dmi_rdata;
   logic [1:0]  dmi_resp;
   logic        dmactive;
   logic        ndmreset;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;
   logic [33:0] sb_q[$];
   logic [31:0] last_rd;

   jtag_dmi_target #(.ACCESS_LATENCY(1), .CMD_LATENCY(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dmi_addr(dmi_addr),
      .dmi_wdata(dmi_wdata),
      .dmi_op(dmi_op),
      .dmi_req_valid(dmi_req_valid),
      .dmi_req_ready(dmi_req_ready),
      .dmi_rdata(dmi_rdata),
      .dmi_resp(dmi_resp),
      .dmactive(dmactive),
      .ndmreset(ndmreset),
      .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && dmi_req_ready) begin
         logic [33:0] e;
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: ready with no pending request rdata=%h resp=%0d",
                     dmi_rdata, dmi_resp);
         end else begin
            e = sb_q.pop_front();
            if ({dmi_rdata, dmi_resp} !== e) begin
               n_fail++;
               $display("FAIL sb_resp: got rdata=%h resp=%0d, want rdata=%h resp=%0d",
                        dmi_rdata, dmi_resp, e[33:2], e[1:0]);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [6:0] a,
                        input logic [31:0] wd, input logic [31:0] rexp,
                        output int lat, output logic after);
      logic [31:0] er;
      er = (op == 2'd1) ? rexp : last_rd;
      if (op == 2'd1)
         last_rd = rexp;
      sb_q.push_back({er, (op == 2'd3) ? 2'd2 : 2'd0});
      dmi_op        = op;
      dmi_addr      = a;
      dmi_wdata     = wd;
      dmi_req_valid = 1'b1;
      lat = 0;
      after = 1'b0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (dmi_req_ready)
            break;
         if (lat > 40) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no ready for addr %h op %0d", a, op);
            void'(sb_q.pop_back());
            lat = -1;
            break;
         end
      end
      dmi_req_valid = 1'b0;
      dmi_op        = 2'd0;
      @(negedge clk);
      after = dmi_req_ready;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      int lat;
      logic aft;
      rst_n = 1'b0;
      last_rd = 32'h0;
      wait_cyc(3);
      n_checks++;
      if ({dmi_req_ready, dmi_rdata, dmi_resp, dmactive, ndmreset, halted} !== 38'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b rdata=%h resp=%0d act=%b ndm=%b hlt=%b, want all 0",
                  dmi_req_ready, dmi_rdata, dmi_resp, dmactive, ndmreset, halted);
      end
      rst_n = 1'b1;
      wait_cyc(1);
      issue(2'd1, 7'h11, 32'h0, 32'h0000_0C82, lat, aft);
      n_checks++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL reset_latency: got %0d cycles, want 2", lat);
      end
      n_checks++;
      if (aft !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulse_width: ready got %b next cycle, want 0", aft);
      end
   endtask

   task automatic test_data;
      int lat;
      logic aft;
      issue(2'd2, 7'h10, 32'h1, 32'h0, lat, aft);
      n_checks++;
      if (dmactive !== 1'b1) begin
         n_fail++;
         $display("FAIL data_dmactive: got %b, want 1", dmactive);
      end
      issue(2'd2, 7'h04, 32'hDEAD_BEEF, 32'h0, lat, aft);
      issue(2'd1, 7'h04, 32'h0, 32'hDEAD_BEEF, lat, aft);
      issue(2'd2, 7'h05, 32'h1234_5678, 32'h0, lat, aft);
      issue(2'd1, 7'h05, 32'h0, 32'h1234_5678, lat, aft);
      issue(2'd3, 7'h04, 32'h5555_5555, 32'h0, lat, aft);
      issue(2'd1, 7'h04, 32'h0, 32'hDEAD_BEEF, lat, aft);
      issue(2'd0, 7'h05, 32'h0, 32'h0, lat, aft);
      issue(2'd2, 7'h33, 32'hFFFF_FFFF, 32'h0, lat, aft);
      issue(2'd1, 7'h33, 32'h0, 32'h0, lat, aft);
      issue(2'd1, 7'h17, 32'h0, 32'h0, lat, aft);
      issue(2'd2, 7'h10, 32'h3, 32'h0, lat, aft);
      n_checks++;
      if (ndmreset !== 1'b1) begin
         n_fail++;
         $display("FAIL data_ndmreset: got %b, want 1", ndmreset);
      end
      issue(2'd1, 7'h10, 32'h0, 32'h3, lat, aft);
      issue(2'd2, 7'h10, 32'h1, 32'h0, lat, aft);
   endtask

   task automatic test_cmderr;
      int lat;
      logic aft;
      issue(2'd2, 7'h17, 32'h0022_1005, 32'h0, lat, aft);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0402, lat, aft);
      issue(2'd2, 7'h16, 32'h0000_0700, 32'h0, lat, aft);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0002, lat, aft);
      issue(2'd2, 7'h17, 32'h0100_0000, 32'h0, lat, aft);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0202, lat, aft);
      issue(2'd2, 7'h16, 32'h0000_0200, 32'h0, lat, aft);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0002, lat, aft);
   endtask

   task automatic test_halt_cmd;
      int lat;
      logic aft;
      issue(2'd2, 7'h10, 32'h8000_0001, 32'h0, lat, aft);
      n_checks++;
      if (halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_output: got %b, want 1", halted);
      end
      issue(2'd1, 7'h11, 32'h0, 32'h0000_0382, lat, aft);
      issue(2'd2, 7'h17, 32'h0022_1005, 32'h0, lat, aft);
      issue(2'd1, 7'h04, 32'h0, 32'h0, lat, aft);
      wait_cyc(8);
      issue(2'd2, 7'h17, 32'h0022_0777, 32'h0, lat, aft);
      wait_cyc(8);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0102, lat, aft);
      issue(2'd2, 7'h16, 32'h0000_0700, 32'h0, lat, aft);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0002, lat, aft);
      issue(2'd1, 7'h04, 32'h0, 32'h0000_1005, lat, aft);
      issue(2'd2, 7'h17, 32'h0022_1234, 32'h0, lat, aft);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_1002, lat, aft);
      wait_cyc(8);
      issue(2'd1, 7'h04, 32'h0, 32'h0000_1234, lat, aft);
      issue(2'd2, 7'h10, 32'h4000_0001, 32'h0, lat, aft);
      n_checks++;
      if (halted !== 1'b0) begin
         n_fail++;
         $display("FAIL resume_output: got %b, want 0", halted);
      end
      issue(2'd1, 7'h11, 32'h0, 32'h0003_0C82, lat, aft);
      issue(2'd2, 7'h10, 32'h0, 32'h0, lat, aft);
      issue(2'd1, 7'h04, 32'h0, 32'h0, lat, aft);
      issue(2'd1, 7'h11, 32'h0, 32'h0000_0C82, lat, aft);
      issue(2'd2, 7'h05, 32'h0000_ABCD, 32'h0, lat, aft);
      issue(2'd1, 7'h05, 32'h0, 32'h0, lat, aft);
   endtask

   task automatic test_reset_mid;
      int lat;
      logic aft;
      logic seen;
      issue(2'd2, 7'h10, 32'h1, 32'h0, lat, aft);
      issue(2'd2, 7'h04, 32'hCAFE_F00D, 32'h0, lat, aft);
      issue(2'd1, 7'h04, 32'h0, 32'hCAFE_F00D, lat, aft);
      dmi_op        = 2'd1;
      dmi_addr      = 7'h04;
      dmi_wdata     = 32'h0;
      dmi_req_valid = 1'b1;
      @(negedge clk);
      rst_n         = 1'b0;
      dmi_req_valid = 1'b0;
      dmi_op        = 2'd0;
      last_rd       = 32'h0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (dmi_req_ready)
            seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_no_ready: ready got %b during reset, want 0", seen);
      end
      n_checks++;
      if ({dmi_rdata, dmi_resp, dmactive, ndmreset, halted} !== 37'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got rdata=%h resp=%0d act=%b ndm=%b hlt=%b, want all 0",
                  dmi_rdata, dmi_resp, dmactive, ndmreset, halted);
      end
      rst_n = 1'b1;
      wait_cyc(1);
      issue(2'd1, 7'h16, 32'h0, 32'h0000_0002, lat, aft);
   endtask

   initial begin
      rst_n         = 1'b0;
      dmi_addr      = 7'h0;
      dmi_wdata     = 32'h0;
      dmi_op        = 2'd0;
      dmi_req_valid = 1'b0;
      last_rd       = 32'h0;
      @(negedge clk);
      test_reset();
      test_data();
      test_cmderr();
      test_halt_cmd();
      test_reset_mid();
      wait_cyc(3);
      n_checks++;
      if (sb_q.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d responses outstanding, want 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
